// File: rtl/ahbl_master_arbiter.sv
// Round-robin AHB-Lite multi-master arbiter: muxes NUM_MASTERS master ports onto one slave-side bus.
// Ownership changes only at idle, unlocked boundaries, so no transfer state is ever buffered.
module ahbl_master_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                              HCLK,
    input  logic                              HRESETn,
    // master side
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_HADDR,
    input  logic [NUM_MASTERS*2-1:0]          M_HTRANS,
    input  logic [NUM_MASTERS-1:0]            M_HWRITE,
    input  logic [NUM_MASTERS*3-1:0]          M_HSIZE,
    input  logic [NUM_MASTERS*3-1:0]          M_HBURST,
    input  logic [NUM_MASTERS*4-1:0]          M_HPROT,
    input  logic [NUM_MASTERS-1:0]            M_HMASTLOCK,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_HWDATA,
    output logic [NUM_MASTERS-1:0]            M_HREADY,
    output logic [NUM_MASTERS-1:0]            M_HRESP,
    output logic [DATA_WIDTH-1:0]             M_HRDATA,
    // slave side
    output logic [ADDR_WIDTH-1:0]             HADDR,
    output logic [1:0]                        HTRANS,
    output logic                              HWRITE,
    output logic [2:0]                        HSIZE,
    output logic [2:0]                        HBURST,
    output logic [3:0]                        HPROT,
    output logic                              HMASTLOCK,
    output logic [DATA_WIDTH-1:0]             HWDATA,
    input  logic                              HREADY,
    input  logic                              HRESP,
    input  logic [DATA_WIDTH-1:0]             HRDATA,
    output logic [2:0]                        HMASTER
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic       RESP_OKAY    = 1'b0;

    logic [2:0]             owner;
    logic [2:0]             data_owner;
    logic                   data_valid;

    logic [1:0]             sel_htrans;
    logic                   sel_hmastlock;
    logic [NUM_MASTERS-1:0] nonseq_req;
    logic [2:0]             next_owner;
    logic                   other_req;
    logic                   handover;

    // Address/control mux: the owner's signals pass straight through with no added latency.
    // NOTE: every combinational output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        HADDR         = '0;
        sel_htrans    = TRANS_IDLE;
        HWRITE        = 1'b0;
        HSIZE         = '0;
        HBURST        = '0;
        HPROT         = '0;
        sel_hmastlock = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner == 3'(i)) begin
                HADDR         = M_HADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_htrans    = M_HTRANS[i*2 +: 2];
                HWRITE        = M_HWRITE[i];
                HSIZE         = M_HSIZE[i*3 +: 3];
                HBURST        = M_HBURST[i*3 +: 3];
                HPROT         = M_HPROT[i*4 +: 4];
                sel_hmastlock = M_HMASTLOCK[i];
            end
        end
    end

    // Slaves share HRESETn, so nothing may look like a live transfer while it is low.
    assign HTRANS    = HRESETn ? sel_htrans : TRANS_IDLE;
    assign HMASTLOCK = HRESETn & sel_hmastlock;
    assign HMASTER   = owner;
    assign M_HRDATA  = HRDATA;

    always_comb begin
        HWDATA = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (data_owner == 3'(i)) begin
                HWDATA = M_HWDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            nonseq_req[i] = (M_HTRANS[i*2 +: 2] == TRANS_NONSEQ);
        end
    end

    // Round-robin scan: lowest requester above the owner first, then wrap to the lowest below it.
    always_comb begin
        next_owner = owner;
        other_req  = 1'b0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!other_req && nonseq_req[j] && (3'(j) > owner)) begin
                other_req  = 1'b1;
                next_owner = 3'(j);
            end
        end
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (!other_req && nonseq_req[j] && (3'(j) < owner)) begin
                other_req  = 1'b1;
                next_owner = 3'(j);
            end
        end
    end

    // BUSY/SEQ and a held lock all keep the bus, so bursts and locked sequences stay whole.
    assign handover = HREADY && (sel_htrans == TRANS_IDLE) && !sel_hmastlock && other_req;

    // Owner drives the slave's HREADY/HRESP; idle non-owners see a ready bus, requesters are stalled.
    always_comb begin
        M_HREADY = '0;
        M_HRESP  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (owner == 3'(i)) begin
                M_HREADY[i] = HREADY;
                M_HRESP[i]  = HRESP;
            end else begin
                M_HREADY[i] = (M_HTRANS[i*2 +: 2] == TRANS_IDLE);
                M_HRESP[i]  = (data_owner == 3'(i)) ? HRESP : RESP_OKAY;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values in the same delta.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            owner      <= '0;
            data_owner <= '0;
            data_valid <= 1'b0;
        end else begin
            if (handover) begin
                owner <= next_owner;
            end
            if (HREADY) begin
                data_owner <= owner;
                data_valid <= HTRANS[1];
            end
        end
    end

    // A switch only happens after an IDLE address phase, so a departed owner never has a live data phase.
    handover_leaves_idle_data : assert property (
        @(posedge HCLK) disable iff (!HRESETn)
        (data_owner != owner) |-> !data_valid
    );

endmodule
